rgb_to_ycbcr_stream: RTL

//  Downstream stage of the demosaic block. After demosaic asserts done, scans the full-resolution R/G/B

---
 rtl/rgb_to_ycbcr_stream.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/rgb_to_ycbcr_stream.sv
`default_nettype none
// ============================================================================
// Module      : rgb_to_ycbcr_stream
// Description : Scans the full-resolution R/G/B pixel memories in raster
//               order once demosaic is done. Converts each pixel to BT.601
//               full-range YCbCr with 8-bit fixed-point coefficients.
//               Streams one pixel per cycle on a valid/ready interface with
//               backpressure, and flags the final pixel of the frame.
// Ports       : clk, reset      - rising-edge clock, async active-high reset
//               start           - demosaic done (level, sampled in IDLE)
//               rd_addr         - shared read address for R/G/B memories
//               rdata_r/g/b     - memory data, combinational on rd_addr
//               out_valid/ready - output stream handshake
//               y, cb, cr       - converted pixel (chroma offset by 128)
//               out_last        - marks pixel IMG_W*IMG_H-1
//               busy, finished  - RUN/DRAIN indicator, sticky frame-done
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_to_ycbcr_stream #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rdata_r,
    input  logic [7:0]    rdata_g,
    input  logic [7:0]    rdata_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    y,
    output logic [7:0]    cb,
    output logic [7:0]    cr,
    output logic          out_last,
    output logic          busy,
    output logic          finished
);

    localparam int            C_NPIX      = IMG_W * IMG_H;
    localparam logic [AW-1:0] C_LAST_ADDR = AW'(C_NPIX - 1);

    // Coefficients, Q8 signed, 18-bit working width
    localparam logic signed [17:0] C_Y_R  =  18'sd77;
    localparam logic signed [17:0] C_Y_G  =  18'sd150;
    localparam logic signed [17:0] C_Y_B  =  18'sd29;
    localparam logic signed [17:0] C_CB_R = -18'sd43;
    localparam logic signed [17:0] C_CB_G = -18'sd85;
    localparam logic signed [17:0] C_CB_B =  18'sd128;
    localparam logic signed [17:0] C_CR_R =  18'sd128;
    localparam logic signed [17:0] C_CR_G = -18'sd107;
    localparam logic signed [17:0] C_CR_B = -18'sd21;
    localparam logic signed [17:0] C_RND  =  18'sd128;
    localparam logic signed [17:0] C_OFS  =  18'sd128;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Pipeline registers
    logic [AW-1:0]      r_rd_addr;
    logic               r_v0;
    logic               r_v1;
    logic               r_v2;
    logic               r_v3;
    logic               r_l1;
    logic               r_l2;
    logic               r_l3;
    logic [7:0]         r_r1;
    logic [7:0]         r_g1;
    logic [7:0]         r_b1;
    logic signed [17:0] r_ys;
    logic signed [17:0] r_cbs;
    logic signed [17:0] r_crs;
    logic [7:0]         r_y;
    logic [7:0]         r_cb;
    logic [7:0]         r_cr;

    logic               w_adv;
    logic               w_at_last;
    logic               w_accept_last;
    logic signed [17:0] w_r;
    logic signed [17:0] w_g;
    logic signed [17:0] w_b;
    logic signed [17:0] w_ys;
    logic signed [17:0] w_cbs;
    logic signed [17:0] w_crs;
    logic signed [17:0] w_y_t;
    logic signed [17:0] w_cb_t;
    logic signed [17:0] w_cr_t;

    // Saturate a signed intermediate to the 8-bit unsigned output range
    function automatic logic [7:0] clamp8(input logic signed [17:0] v);
        logic [7:0] res;
        if (v < 18'sd0) begin
            res = 8'd0;
        end else if (v > 18'sd255) begin
            res = 8'd255;
        end else begin
            res = v[7:0];
        end
        return res;
    endfunction

    // The whole pipe moves together; only a held output pixel stalls it,
    // and holding rd_addr keeps the combinational memory data consistent.
    assign w_adv         = !(r_v3 && !out_ready);
    assign w_at_last     = (r_rd_addr == C_LAST_ADDR);
    assign w_accept_last = r_v3 && out_ready && r_l3;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_adv && r_v0 && w_at_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_accept_last) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_FIN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Arithmetic: zero-extend the captured bytes, then signed MAC
    // ------------------------------------------------------------------
    assign w_r = $signed({10'd0, r_r1});
    assign w_g = $signed({10'd0, r_g1});
    assign w_b = $signed({10'd0, r_b1});

    assign w_ys  = C_Y_R  * w_r + C_Y_G  * w_g + C_Y_B  * w_b;
    assign w_cbs = C_CB_R * w_r + C_CB_G * w_g + C_CB_B * w_b;
    assign w_crs = C_CR_R * w_r + C_CR_G * w_g + C_CR_B * w_b;

    // Round-half-up then floor shift; chroma re-centred after the shift
    assign w_y_t  = (r_ys + C_RND) >>> 8;
    assign w_cb_t = ((r_cbs + C_RND) >>> 8) + C_OFS;
    assign w_cr_t = ((r_crs + C_RND) >>> 8) + C_OFS;

    // ------------------------------------------------------------------
    // Pipeline: S0 address, S1 capture, S2 sums, S3 round/clamp
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_addr <= '0;
            r_v0      <= 1'b0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_v3      <= 1'b0;
            r_l1      <= 1'b0;
            r_l2      <= 1'b0;
            r_l3      <= 1'b0;
            r_r1      <= 8'd0;
            r_g1      <= 8'd0;
            r_b1      <= 8'd0;
            r_ys      <= 18'sd0;
            r_cbs     <= 18'sd0;
            r_crs     <= 18'sd0;
            r_y       <= 8'd0;
            r_cb      <= 8'd0;
            r_cr      <= 8'd0;
        end else if (w_adv) begin
            // S0: issue addresses 0..last exactly once, never wrap
            if (r_state == S_IDLE && start) begin
                r_v0      <= 1'b1;
                r_rd_addr <= '0;
            end else if (r_state == S_RUN && r_v0) begin
                if (w_at_last) begin
                    r_v0 <= 1'b0;
                end else begin
                    r_rd_addr <= r_rd_addr + 1'b1;
                end
            end

            // S1
            r_v1 <= r_v0;
            r_l1 <= r_v0 && w_at_last;
            if (r_v0) begin
                r_r1 <= rdata_r;
                r_g1 <= rdata_g;
                r_b1 <= rdata_b;
            end

            // S2
            r_v2 <= r_v1;
            r_l2 <= r_v1 && r_l1;
            if (r_v1) begin
                r_ys  <= w_ys;
                r_cbs <= w_cbs;
                r_crs <= w_crs;
            end

            // S3
            r_v3 <= r_v2;
            r_l3 <= r_v2 && r_l2;
            if (r_v2) begin
                r_y  <= clamp8(w_y_t);
                r_cb <= clamp8(w_cb_t);
                r_cr <= clamp8(w_cr_t);
            end
        end
    end

    assign rd_addr   = r_rd_addr;
    assign out_valid = r_v3;
    assign out_last  = r_l3;
    assign y         = r_y;
    assign cb        = r_cb;
    assign cr        = r_cr;
    assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign finished  = (r_state == S_FIN);

endmodule
`default_nettype wire
